// File: rtl/weight_stream_loader.sv
// weight_stream_loader
//
// Feeds the 1D-conv weight BRAM banks from a host AXI-Stream. When the control
// FSM raises weight_req, a fixed number of words is pulled from the stream.
// The words are written round-robin across the Dimension banks through port A:
// word i goes to bank i % Dimension at row base + i / Dimension.
// weight_ack pulses for one cycle alongside the final write strobe.
//
// Ports
//   clk            system clock
//   rst            synchronous active-low reset
//   weight_req     level request, held by the control FSM until weight_ack
//   weight_ack     one-cycle pulse: load complete
//   load_words     number of words to load, latched when a request is taken
//   base_addr      first BRAM row, latched when a request is taken
//   s_tdata/s_tvalid/s_tlast/s_tready   AXI-Stream slave
//   ena_weight     BRAM port-A enable (one per write)
//   wea_weight     one-hot bank write enable
//   addra_weight   BRAM port-A address
//   dina_weight    BRAM port-A data, shared by all banks
//   busy           high while loading or acknowledging
//   err_early_last sticky: tlast arrived before load_words were written
//   words_loaded   words written in the current/last load
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for weight_req; latches count and base when it arrives
// LOAD  | s_tready high; each accepted beat becomes a write next cycle
// ACK   | weight_ack high (same cycle as the final write strobe)

module weight_stream_loader #(
  parameter int DW             = 16,
  parameter int Dimension      = 16,
  parameter int ADDRESS_LENGTH = 10,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      weight_req,
  output logic                      weight_ack,
  input  logic [CNT_WIDTH-1:0]      load_words,
  input  logic [ADDRESS_LENGTH-1:0] base_addr,
  input  logic [DW-1:0]             s_tdata,
  input  logic                      s_tvalid,
  input  logic                      s_tlast,
  output logic                      s_tready,
  output logic                      ena_weight,
  output logic [Dimension-1:0]      wea_weight,
  output logic [ADDRESS_LENGTH-1:0] addra_weight,
  output logic [DW-1:0]             dina_weight,
  output logic                      busy,
  output logic                      err_early_last,
  output logic [CNT_WIDTH-1:0]      words_loaded
);

  localparam int BW = (Dimension > 1) ? $clog2(Dimension) : 1;

  typedef enum logic [1:0] {IDLE, LOAD, ACK} state_t;

  state_t                    state;
  logic [CNT_WIDTH-1:0]      count_q;
  logic [ADDRESS_LENGTH-1:0] base_q;
  logic [ADDRESS_LENGTH-1:0] row_q;
  logic [BW-1:0]             bank_idx;
  logic                      final_word;
  logic                      bank_wrap;

  // Status outputs are pure decodes of the state register.
  assign s_tready   = (state == LOAD);
  assign busy       = (state != IDLE);
  assign weight_ack = (state == ACK);

  assign final_word = ((words_loaded + CNT_WIDTH'(1)) == count_q);
  assign bank_wrap  = (bank_idx == BW'(Dimension - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      count_q        <= '0;
      base_q         <= '0;
      row_q          <= '0;
      bank_idx       <= '0;
      ena_weight     <= 1'b0;
      wea_weight     <= '0;
      addra_weight   <= '0;
      dina_weight    <= '0;
      err_early_last <= 1'b0;
      words_loaded   <= '0;
    end else begin
      // Strobes are single-cycle; address/data simply hold between writes.
      ena_weight <= 1'b0;
      wea_weight <= '0;

      case (state)
        IDLE: begin
          if (weight_req) begin
            count_q        <= load_words;
            base_q         <= base_addr;
            row_q          <= '0;
            bank_idx       <= '0;
            words_loaded   <= '0;
            err_early_last <= 1'b0;
            state          <= (load_words == '0) ? ACK : LOAD;
          end
        end

        LOAD: begin
          if (s_tvalid) begin
            ena_weight   <= 1'b1;
            wea_weight   <= Dimension'(1) << bank_idx;
            addra_weight <= base_q + row_q;   // wraps modulo 2^ADDRESS_LENGTH
            dina_weight  <= s_tdata;
            words_loaded <= words_loaded + CNT_WIDTH'(1);

            if (bank_wrap) begin
              bank_idx <= '0;
              row_q    <= row_q + ADDRESS_LENGTH'(1);
            end else begin
              bank_idx <= bank_idx + BW'(1);
            end

            // The final word wins over tlast: tlast on it is not an error.
            if (final_word) begin
              state <= ACK;
            end else if (s_tlast) begin
              err_early_last <= 1'b1;
              state          <= ACK;
            end
          end
        end

        ACK: state <= IDLE;

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_weight_stream_loader.sv
// Directed bench for weight_stream_loader. Inputs are driven 1 time unit after
// the rising edge; outputs are observed on the falling edge. Stream word i
// always carries 16'hA000 + i, so every write can be checked against its
// expected bank, row and data.

module tb_weight_stream_loader;

  localparam int DW  = 16;
  localparam int DIM = 16;
  localparam int AL  = 10;
  localparam int CW  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          weight_req = 1'b0;
  logic          weight_ack;
  logic [CW-1:0] load_words = '0;
  logic [AL-1:0] base_addr = '0;
  logic [DW-1:0] s_tdata = '0;
  logic          s_tvalid = 1'b0;
  logic          s_tlast = 1'b0;
  logic          s_tready;
  logic          ena_weight;
  logic [DIM-1:0] wea_weight;
  logic [AL-1:0] addra_weight;
  logic [DW-1:0] dina_weight;
  logic          busy;
  logic          err_early_last;
  logic [CW-1:0] words_loaded;

  always #5 clk = ~clk;

  weight_stream_loader #(
    .DW(DW), .Dimension(DIM), .ADDRESS_LENGTH(AL), .CNT_WIDTH(CW)
  ) dut (
    .clk(clk), .rst(rst),
    .weight_req(weight_req), .weight_ack(weight_ack),
    .load_words(load_words), .base_addr(base_addr),
    .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
    .ena_weight(ena_weight), .wea_weight(wea_weight),
    .addra_weight(addra_weight), .dina_weight(dina_weight),
    .busy(busy), .err_early_last(err_early_last), .words_loaded(words_loaded)
  );

  int errors = 0;
  int checks = 0;

  int cyc_cnt = 0;
  always @(posedge clk) cyc_cnt++;

  // Write / handshake monitor
  logic [DIM-1:0] wr_wea [512];
  logic [AL-1:0]  wr_addr[512];
  logic [DW-1:0]  wr_data[512];
  int   n_wr = 0;
  int   acks = 0;
  int   ack_wr_n = 0;
  int   ack_cyc = 0;
  logic ack_ena = 1'b0;
  int   tready_cyc = 0;
  int   acc_total = 0;
  int   strobe_bad = 0;
  logic acc_prev = 1'b0;

  always @(negedge clk) begin
    if (ena_weight === 1'b1) begin
      if (n_wr < 512) begin
        wr_wea[n_wr]  = wea_weight;
        wr_addr[n_wr] = addra_weight;
        wr_data[n_wr] = dina_weight;
      end
      n_wr++;
    end
    if (weight_ack === 1'b1) begin
      acks++;
      ack_wr_n = n_wr;
      ack_cyc  = cyc_cnt;
      ack_ena  = ena_weight;
    end
    if (s_tready === 1'b1) tready_cyc++;
    // A write strobe must appear exactly in the cycle after each accepted beat.
    if (ena_weight !== acc_prev) strobe_bad++;
    acc_prev = s_tvalid && s_tready && rst;
    if (s_tvalid && s_tready && rst) acc_total++;
  end

  // Counts logged writes that differ from the round-robin placement of words 0..n-1.
  function automatic int count_bad(input int w0, input int n, input int base);
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      if (wr_wea[w0+i]  !== (DIM'(1) << (i % DIM)) ||
          wr_addr[w0+i] !== AL'(base + i / DIM) ||
          wr_data[w0+i] !== (16'hA000 + 16'(i)))
        bad++;
    end
    return bad;
  endfunction

  // Raises a request, streams words, drops req on ack, then offers 4 more beats.
  task automatic run_load(input int cnt, input int base, input int mode, input int last_at,
                          input int budget, output int consumed, output int req_edge,
                          output bit timed_out);
    int  idx;
    int  cyc;
    bit  done;
    idx = 0; cyc = 0; done = 0;
    @(posedge clk); #1;
    weight_req = 1'b1;
    load_words = CW'(cnt);
    base_addr  = AL'(base);
    req_edge   = cyc_cnt + 1;
    while (!done && cyc < budget) begin
      s_tvalid = (mode == 0) ? 1'b1 : ((cyc >= 10 && cyc < 15) ? 1'b0 : (cyc % 2 == 0));
      s_tdata  = 16'hA000 + 16'(idx);
      s_tlast  = (idx == last_at);
      @(negedge clk);
      if (s_tvalid && s_tready) idx++;
      if (weight_ack) done = 1;
      @(posedge clk); #1;
      cyc++;
    end
    weight_req = 1'b0;
    repeat (4) begin
      s_tvalid = 1'b1;
      s_tdata  = 16'hA000 + 16'(idx);
      s_tlast  = 1'b0;
      @(posedge clk); #1;
    end
    s_tvalid  = 1'b0;
    consumed  = idx;
    timed_out = !done;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b want 0", busy); end
    checks++; if (weight_ack !== 1'b0) begin errors++; $display("FAIL rst_ack got %b want 0", weight_ack); end
    checks++; if (s_tready !== 1'b0) begin errors++; $display("FAIL rst_tready got %b want 0", s_tready); end
    checks++; if (ena_weight !== 1'b0) begin errors++; $display("FAIL rst_ena got %b want 0", ena_weight); end
    checks++; if (wea_weight !== '0) begin errors++; $display("FAIL rst_wea got %h want 0", wea_weight); end
    checks++; if (addra_weight !== '0) begin errors++; $display("FAIL rst_addr got %h want 0", addra_weight); end
    checks++; if (dina_weight !== '0) begin errors++; $display("FAIL rst_din got %h want 0", dina_weight); end
    checks++; if (err_early_last !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err_early_last); end
    checks++; if (words_loaded !== '0) begin errors++; $display("FAIL rst_words got %0d want 0", words_loaded); end
    @(posedge clk); #1;
    rst = 1'b1;
  endtask

  task automatic test_continuous();
    int w0, a0, c0, s0, got, req_e, bad;
    bit to;
    w0 = n_wr; a0 = acks; c0 = acc_total; s0 = strobe_bad;
    run_load(48, 0, 0, -1, 200, got, req_e, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL cont_timeout got %b want 0", to); end
    checks++; if (n_wr - w0 !== 48) begin errors++; $display("FAIL cont_writes got %0d want 48", n_wr - w0); end
    bad = count_bad(w0, 48, 0);
    checks++; if (bad !== 0) begin errors++; $display("FAIL cont_contents bad_words=%0d want 0", bad); end
    checks++; if (wr_wea[w0+17] !== 16'h0002 || wr_addr[w0+17] !== 10'd1) begin errors++;
      $display("FAIL cont_word17 got wea=%h addr=%0d want wea=0002 addr=1", wr_wea[w0+17], wr_addr[w0+17]); end
    checks++; if (wr_wea[w0+47] !== 16'h8000 || wr_addr[w0+47] !== 10'd2) begin errors++;
      $display("FAIL cont_word47 got wea=%h addr=%0d want wea=8000 addr=2", wr_wea[w0+47], wr_addr[w0+47]); end
    checks++; if (acks - a0 !== 1) begin errors++; $display("FAIL cont_ack_count got %0d want 1", acks - a0); end
    checks++; if (ack_wr_n - w0 !== 48 || ack_ena !== 1'b1) begin errors++;
      $display("FAIL cont_ack_with_last got writes=%0d ena=%b want 48 1", ack_wr_n - w0, ack_ena); end
    checks++; if (ack_cyc !== req_e + 48) begin errors++;
      $display("FAIL cont_ack_time got cycle %0d want %0d", ack_cyc, req_e + 48); end
    checks++; if (acc_total - c0 !== 48) begin errors++; $display("FAIL cont_accepts got %0d want 48", acc_total - c0); end
    checks++; if (s_tready !== 1'b0 || busy !== 1'b0) begin errors++;
      $display("FAIL cont_idle_after got tready=%b busy=%b want 0 0", s_tready, busy); end
    checks++; if (err_early_last !== 1'b0 || words_loaded !== 16'd48) begin errors++;
      $display("FAIL cont_status got err=%b words=%0d want 0 48", err_early_last, words_loaded); end
    checks++; if (strobe_bad !== s0) begin errors++; $display("FAIL cont_strobes got %0d stray want 0", strobe_bad - s0); end
  endtask

  task automatic test_gapped();
    int w0, a0, s0, got, req_e, bad;
    bit to;
    w0 = n_wr; a0 = acks; s0 = strobe_bad;
    run_load(48, 0, 1, -1, 300, got, req_e, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL gap_timeout got %b want 0", to); end
    checks++; if (n_wr - w0 !== 48) begin errors++; $display("FAIL gap_writes got %0d want 48", n_wr - w0); end
    bad = count_bad(w0, 48, 0);
    checks++; if (bad !== 0) begin errors++; $display("FAIL gap_contents bad_words=%0d want 0", bad); end
    checks++; if (words_loaded !== 16'd48) begin errors++; $display("FAIL gap_words got %0d want 48", words_loaded); end
    checks++; if (acks - a0 !== 1) begin errors++; $display("FAIL gap_ack_count got %0d want 1", acks - a0); end
    checks++; if (strobe_bad !== s0) begin errors++; $display("FAIL gap_strobes got %0d stray want 0", strobe_bad - s0); end
  endtask

  task automatic test_zero_count();
    int w0, a0, t0, got, req_e;
    bit to;
    w0 = n_wr; a0 = acks; t0 = tready_cyc;
    run_load(0, 5, 0, -1, 20, got, req_e, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL zero_timeout got %b want 0", to); end
    checks++; if (ack_cyc !== req_e) begin errors++; $display("FAIL zero_ack_time got cycle %0d want %0d", ack_cyc, req_e); end
    checks++; if (acks - a0 !== 1) begin errors++; $display("FAIL zero_ack_count got %0d want 1", acks - a0); end
    checks++; if (n_wr - w0 !== 0) begin errors++; $display("FAIL zero_writes got %0d want 0", n_wr - w0); end
    checks++; if (tready_cyc - t0 !== 0) begin errors++; $display("FAIL zero_tready got %0d cycles want 0", tready_cyc - t0); end
  endtask

  task automatic test_early_last();
    int w0, a0, c0, got, req_e, bad;
    bit to;
    w0 = n_wr; a0 = acks; c0 = acc_total;
    run_load(32, 7, 0, 9, 100, got, req_e, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL early_timeout got %b want 0", to); end
    checks++; if (n_wr - w0 !== 10) begin errors++; $display("FAIL early_writes got %0d want 10", n_wr - w0); end
    bad = count_bad(w0, 10, 7);
    checks++; if (bad !== 0) begin errors++; $display("FAIL early_contents bad_words=%0d want 0", bad); end
    checks++; if (wr_wea[w0+9] !== 16'h0200 || wr_addr[w0+9] !== 10'd7) begin errors++;
      $display("FAIL early_word9 got wea=%h addr=%0d want wea=0200 addr=7", wr_wea[w0+9], wr_addr[w0+9]); end
    checks++; if (err_early_last !== 1'b1) begin errors++; $display("FAIL early_err got %b want 1", err_early_last); end
    checks++; if (acks - a0 !== 1 || ack_wr_n - w0 !== 10) begin errors++;
      $display("FAIL early_ack got acks=%0d at_write=%0d want 1 10", acks - a0, ack_wr_n - w0); end
    checks++; if (words_loaded !== 16'd10) begin errors++; $display("FAIL early_words got %0d want 10", words_loaded); end
    checks++; if (acc_total - c0 !== 10) begin errors++; $display("FAIL early_unconsumed got %0d accepts want 10", acc_total - c0); end
  endtask

  task automatic test_addr_wrap();
    int w0, got, req_e, bad;
    bit to;
    w0 = n_wr;
    run_load(32, 1023, 0, -1, 100, got, req_e, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL wrap_timeout got %b want 0", to); end
    checks++; if (n_wr - w0 !== 32) begin errors++; $display("FAIL wrap_writes got %0d want 32", n_wr - w0); end
    checks++; if (wr_addr[w0] !== 10'd1023 || wr_addr[w0+15] !== 10'd1023) begin errors++;
      $display("FAIL wrap_row0 got %0d %0d want 1023 1023", wr_addr[w0], wr_addr[w0+15]); end
    checks++; if (wr_addr[w0+16] !== 10'd0 || wr_addr[w0+31] !== 10'd0) begin errors++;
      $display("FAIL wrap_row1 got %0d %0d want 0 0", wr_addr[w0+16], wr_addr[w0+31]); end
    bad = count_bad(w0, 32, 1023);
    checks++; if (bad !== 0) begin errors++; $display("FAIL wrap_contents bad_words=%0d want 0", bad); end
    checks++; if (err_early_last !== 1'b0) begin errors++; $display("FAIL wrap_err_cleared got %b want 0", err_early_last); end
  endtask

  task automatic test_reset_mid_load();
    int w0, w1, a0, idx, cyc, got, req_e, bad;
    bit to;
    w0 = n_wr; a0 = acks; idx = 0; cyc = 0;
    @(posedge clk); #1;
    weight_req = 1'b1; load_words = 16'd48; base_addr = 10'd0;
    while (idx < 20 && cyc < 100) begin
      s_tvalid = 1'b1; s_tdata = 16'hA000 + 16'(idx); s_tlast = 1'b0;
      @(negedge clk);
      if (s_tvalid && s_tready) idx++;
      @(posedge clk); #1;
      cyc++;
    end
    checks++; if (idx !== 20) begin errors++; $display("FAIL midrst_accepts got %0d want 20", idx); end
    rst = 1'b0; weight_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0 || weight_ack !== 1'b0 || s_tready !== 1'b0) begin errors++;
      $display("FAIL midrst_ctrl got busy=%b ack=%b tready=%b want 0 0 0", busy, weight_ack, s_tready); end
    checks++; if (ena_weight !== 1'b0 || wea_weight !== '0 || addra_weight !== '0 || dina_weight !== '0) begin errors++;
      $display("FAIL midrst_bram got ena=%b wea=%h addr=%h din=%h want all 0", ena_weight, wea_weight, addra_weight, dina_weight); end
    checks++; if (words_loaded !== '0 || err_early_last !== 1'b0) begin errors++;
      $display("FAIL midrst_status got words=%0d err=%b want 0 0", words_loaded, err_early_last); end
    checks++; if (n_wr - w0 !== 20) begin errors++; $display("FAIL midrst_writes got %0d want 20", n_wr - w0); end
    @(posedge clk); #1;
    rst = 1'b1; s_tvalid = 1'b0;
    repeat (3) @(posedge clk);
    checks++; if (acks - a0 !== 0) begin errors++; $display("FAIL midrst_no_ack got %0d acks want 0", acks - a0); end
    w1 = n_wr;
    run_load(16, 100, 0, -1, 100, got, req_e, to);
    checks++; if (to !== 1'b0) begin errors++; $display("FAIL fresh_timeout got %b want 0", to); end
    checks++; if (n_wr - w1 !== 16) begin errors++; $display("FAIL fresh_writes got %0d want 16", n_wr - w1); end
    checks++; if (wr_wea[w1] !== 16'h0001 || wr_addr[w1] !== 10'd100) begin errors++;
      $display("FAIL fresh_first got wea=%h addr=%0d want 0001 100", wr_wea[w1], wr_addr[w1]); end
    bad = count_bad(w1, 16, 100);
    checks++; if (bad !== 0) begin errors++; $display("FAIL fresh_contents bad_words=%0d want 0", bad); end
    checks++; if (acks - a0 !== 1) begin errors++; $display("FAIL fresh_ack got %0d want 1", acks - a0); end
  endtask

  // req held high through ack with a zero count: IDLE re-samples it after ack.
  task automatic test_back_to_back();
    int a0;
    a0 = acks;
    @(posedge clk); #1;
    weight_req = 1'b1; load_words = '0; base_addr = '0;
    repeat (4) @(posedge clk);
    #1 weight_req = 1'b0;
    repeat (4) @(posedge clk);
    checks++; if (acks - a0 !== 2) begin errors++; $display("FAIL b2b_acks got %0d want 2", acks - a0); end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gapped();
    test_zero_count();
    test_early_last();
    test_addr_wrap();
    test_reset_mid_load();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
